port_arbiter: RTL and testbench
===============================

PORT_ARBITER -- requirements
Module: port_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 16: max cycles a grant may wait for port_ready before forced release (legal range 2..255).
REQ-002 Parameter N_REQ, fixed 4: requester count, matching the 4:1 Mux2 select range.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  4  per-requester request level, bit i = requester i; held high until its done or err pulse.
REQ-006 port_ready  input  1  shared port completes current access this cycle.
REQ-007 grant  output  4  one-hot owner of the shared port; all-zero when idle.
REQ-008 sel  output  2  select driven into the Mux2 in front of the shared port; binary index of the owner.
REQ-009 port_valid  output  1  access presented to the shared port.
REQ-010 done  output  4  one-cycle completion pulse to the owning requester.
REQ-011 err  output  1  one-cycle timeout pulse.
REQ-012 busy  output  1  high while in state BUSY.

Function
REQ-013 The FSM SHALL have exactly two states: IDLE and BUSY.
REQ-014 In IDLE with req != 0, the block SHALL pick the first set bit scanning from ptr upward, mod 4, and enter BUSY on the next edge.
REQ-015 On entering BUSY, the block SHALL assert grant[w], sel = w, port_valid = 1, busy = 1, and clear the wait counter to 0.
REQ-016 In BUSY, grant, sel and port_valid SHALL be held constant; req changes, including the owner dropping req, SHALL be ignored until release.
REQ-017 In BUSY with port_ready = 1, the block SHALL pulse done[w] on the next cycle, clear grant/port_valid/busy, set ptr = (w+1) mod 4, and return to IDLE.
REQ-018 In BUSY with port_ready = 0, the wait counter SHALL increment; when it reaches TIMEOUT-1 without port_ready, the block SHALL release exactly as REQ-017, but pulse err instead of done.
REQ-019 If port_ready arrives on the cycle the counter hits TIMEOUT-1, the block SHALL treat it as completion (done, no err).
REQ-020 Every transaction SHALL spend at least one cycle in IDLE between releases, so the minimum period is 2 cycles per grant.
REQ-021 sel SHALL retain its last owner's index while idle, so the mux output stays stable.
REQ-022 Latency: the first req rise in IDLE SHALL produce grant and port_valid exactly one cycle later.
REQ-023 grant SHALL never have more than one bit set; done and err SHALL never be high in the same cycle.
REQ-024 The wait counter SHALL be wide enough for 255 and SHALL NOT wrap while in BUSY.

Reset
REQ-025 When rst = 1 at a clock edge, the block SHALL force state IDLE, ptr = 0, counter = 0, grant = 0, sel = 0, port_valid = 0, done = 0, err = 0, busy = 0.
REQ-026 Reset during BUSY SHALL abandon the transaction with no done and no err pulse.
REQ-027 After reset, arbitration SHALL start from requester 0.

Structure
REQ-028 State encodings, N_REQ and the select width (2) SHALL live in a shared package or header, arb_defs, used by port_arbiter and the bench.
REQ-029 The combinational round-robin priority pick SHALL be a sub-module rr_pick(req, ptr -> valid, idx).
REQ-030 port_arbiter SHALL contain only the FSM, ptr, counter and output registers; data muxing stays in the existing Mux2.

Verification
REQ-031 Reset, then req=4'b0100 held, port_ready high 2 cycles after grant -> grant=0100, sel=2 at cycle+1; done=0100 pulse once; ptr becomes 3.
REQ-032 req=4'b1111 held, port_ready=1 each BUSY cycle -> grant order 0,1,2,3,0, one grant every 2 cycles.
REQ-033 TIMEOUT=4, req=4'b0001, port_ready held 0 -> err pulse after 4 BUSY cycles, no done, next grant goes to requester 0 again.
REQ-034 TIMEOUT=4, port_ready=1 on the 4th BUSY cycle -> done pulse, err stays 0.
REQ-035 req=4'b0011, rst asserted during BUSY of requester 0 -> all outputs 0 next cycle, no done; after rst, requester 0 is granted first.
REQ-036 Owner drops req mid-BUSY while req[3] rises -> grant, sel and port_valid unchanged until port_ready; requester 3 is granted after the IDLE cycle.

Source files
------------

// File: rtl/arb_defs.sv
// Shared definitions for the shared-port arbiter: requester count, select
// width, FSM state encoding and a one-hot helper. Used by the RTL and the bench.
package arb_defs;

  // Requester count matches the 4:1 Mux2 in front of the shared port.
  localparam int N_REQ = 4;

  // Select width into the Mux2. The round-robin wrap relies on N_REQ == 2**SEL_W.
  localparam int SEL_W = 2;

  // Wait counter width: holds any TIMEOUT-1 up to 254 without wrapping.
  localparam int CNT_W = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_e;

  // Binary requester index to one-hot grant/done vector.
  function automatic logic [N_REQ-1:0] to_onehot(input logic [SEL_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request bit scanning upward from
// ptr, wrapping mod N_REQ. valid is low when no request is pending.
module rr_pick
  import arb_defs::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [SEL_W-1:0] cand;

  // Scan offsets from highest to lowest so the nearest set bit above ptr wins.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path holds an old value and no latch is inferred.
    valid = 1'b0;
    idx   = ptr;
    cand  = ptr;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      // Adding in SEL_W bits wraps naturally past the top requester.
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/port_arbiter.sv
// Round-robin arbiter for one shared port behind a 4:1 Mux2. Two-state FSM
// (IDLE/BUSY); grants one requester, waits for port_ready, and releases with a
// done pulse, or with an err pulse once the grant has waited TIMEOUT cycles.
// At least one IDLE cycle separates consecutive grants.
module port_arbiter
  import arb_defs::*;
#(
  // Maximum BUSY cycles before a forced release; legal range 2..255.
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             port_ready,
  output logic [N_REQ-1:0] grant,
  output logic [SEL_W-1:0] sel,
  output logic             port_valid,
  output logic [N_REQ-1:0] done,
  output logic             err,
  output logic             busy
);

  // Counter value on the last BUSY cycle allowed before the forced release.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  arb_state_e       state_q;
  logic [SEL_W-1:0] ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [N_REQ-1:0] grant_q;
  logic [SEL_W-1:0] sel_q;
  logic             valid_q;
  logic [N_REQ-1:0] done_q;
  logic             err_q;
  logic             busy_q;

  logic             pick_valid;
  logic [SEL_W-1:0] pick_idx;

  rr_pick u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // FSM, round-robin pointer, wait counter and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      // Reset abandons any transaction in flight: no done or err is emitted.
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      grant_q <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
      // done and err are single-cycle pulses.
      done_q <= '0;
      err_q  <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            state_q <= ST_BUSY;
            grant_q <= to_onehot(pick_idx);
            sel_q   <= pick_idx;
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        ST_BUSY: begin
          // req is ignored here; sel_q holds the owner for the whole grant.
          if (port_ready || (cnt_q == CNT_LAST)) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            ptr_q   <= sel_q + SEL_W'(1);
            // port_ready on the final cycle still counts as completion.
            if (port_ready) begin
              done_q <= grant_q;
            end else begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // sel_q is left untouched on release so the Mux2 output stays stable while idle.
  assign grant      = grant_q;
  assign sel        = sel_q;
  assign port_valid = valid_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_port_arbiter.sv
// Self-checking bench for port_arbiter: directed scenarios followed by random
// req/port_ready/rst traffic, all compared against a transaction-level model.
module tb_port_arbiter;
  import arb_defs::*;

  localparam int TB_TIMEOUT = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_REQ-1:0] req;
  logic             port_ready;
  logic [N_REQ-1:0] grant;
  logic [SEL_W-1:0] sel;
  logic             port_valid;
  logic [N_REQ-1:0] done;
  logic             err;
  logic             busy;

  always #5 clk = ~clk;

  port_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .port_ready (port_ready),
    .grant      (grant),
    .sel        (sel),
    .port_valid (port_valid),
    .done       (done),
    .err        (err),
    .busy       (busy)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: owner index (-1 when nobody holds the port), the
  // requester to start the next scan from, and the BUSY cycles already spent.
  int         m_owner = -1;
  int         m_ptr   = 0;
  int         m_spent = 0;
  int         m_sel   = 0;
  logic [3:0] m_done  = '0;
  logic       m_err   = 1'b0;

  task automatic model_tick();
    m_done = '0;
    m_err  = 1'b0;
    if (rst) begin
      m_owner = -1;
      m_ptr   = 0;
      m_spent = 0;
      m_sel   = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N_REQ; k++) begin
        int j;
        j = (m_ptr + k) % N_REQ;
        if (m_owner < 0 && req[j]) m_owner = j;
      end
      if (m_owner >= 0) begin
        m_spent = 1;
        m_sel   = m_owner;
      end
    end else if (port_ready) begin
      m_done  = 4'(1 << m_owner);
      m_ptr   = (m_owner + 1) % N_REQ;
      m_owner = -1;
    end else if (m_spent >= TB_TIMEOUT) begin
      m_err   = 1'b1;
      m_ptr   = (m_owner + 1) % N_REQ;
      m_owner = -1;
    end else begin
      m_spent++;
    end
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".grant"}, grant, (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, ".sel"}, sel, m_sel);
    check({tag, ".valid"}, port_valid, m_owner >= 0);
    check({tag, ".busy"}, busy, m_owner >= 0);
    check({tag, ".done"}, done, m_done);
    check({tag, ".err"}, err, m_err);
    check({tag, ".onehot"}, $countones(grant) <= 1, 1);
    check({tag, ".excl"}, (|done) && err, 0);
  endtask

  // One clock: the model consumes the same inputs as the DUT, outputs are
  // compared 1 time unit after the edge.
  task automatic step(input string tag);
    @(posedge clk);
    model_tick();
    #1;
    compare_all(tag);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req        = '0;
    port_ready = 1'b0;
    step("rst");
    rst = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    req        = '0;
    port_ready = 1'b0;

    // Reset values.
    do_reset();
    check("t0.grant", grant, 0);
    check("t0.sel", sel, 0);
    check("t0.done", done, 0);

    // Single requester 2, one-cycle latency, done once, pointer moves to 3.
    req = 4'b0100;
    step("t1");
    check("t1.grant", grant, 4'b0100);
    check("t1.sel", sel, 2);
    step("t1");
    port_ready = 1'b1;
    step("t1");
    check("t1.done", done, 4'b0100);
    check("t1.rel", grant, 0);
    check("t1.selhold", sel, 2);
    req        = 4'b0000;
    port_ready = 1'b0;
    step("t1");
    check("t1.done1", done, 0);
    req = 4'b1001;
    step("t1");
    check("t1.ptr3", grant, 4'b1000);
    port_ready = 1'b1;
    step("t1");
    req        = '0;
    port_ready = 1'b0;
    step("t1");

    // All requesting, port always ready: 0,1,2,3,0 every two cycles.
    do_reset();
    req        = 4'b1111;
    port_ready = 1'b1;
    for (int g = 0; g < 5; g++) begin
      step("t2");
      check("t2.grant", grant, 32'd1 << (g % 4));
      step("t2");
      check("t2.done", done, 32'd1 << (g % 4));
    end

    // Timeout: err after four BUSY cycles, no done, requester 0 regranted.
    do_reset();
    req        = 4'b0001;
    port_ready = 1'b0;
    step("t3");
    for (int c = 0; c < 3; c++) begin
      step("t3");
      check("t3.busy", busy, 1);
      check("t3.noerr", err, 0);
    end
    step("t3");
    check("t3.err", err, 1);
    check("t3.nodone", done, 0);
    step("t3");
    check("t3.regrant", grant, 4'b0001);

    // port_ready on the last allowed cycle is a completion, not a timeout.
    do_reset();
    req = 4'b0010;
    step("t4");
    step("t4");
    step("t4");
    step("t4");
    port_ready = 1'b1;
    step("t4");
    check("t4.done", done, 4'b0010);
    check("t4.err", err, 0);
    port_ready = 1'b0;
    req        = '0;
    step("t4");

    // Reset mid-grant: outputs cleared, no done, requester 0 first afterwards.
    do_reset();
    req = 4'b0011;
    step("t5");
    check("t5.grant", grant, 4'b0001);
    rst = 1'b1;
    step("t5");
    check("t5.rgrant", grant, 0);
    check("t5.rdone", done, 0);
    check("t5.rvalid", port_valid, 0);
    rst = 1'b0;
    step("t5");
    check("t5.first", grant, 4'b0001);

    // Owner drops req while requester 3 rises: grant held until port_ready.
    do_reset();
    req = 4'b0001;
    step("t6");
    req = 4'b1000;
    step("t6");
    check("t6.hold", grant, 4'b0001);
    check("t6.sel", sel, 0);
    check("t6.valid", port_valid, 1);
    port_ready = 1'b1;
    step("t6");
    check("t6.done", done, 4'b0001);
    port_ready = 1'b0;
    step("t6");
    check("t6.next", grant, 4'b1000);

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 99) < 2);
      req        = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      port_ready = ($urandom_range(0, 3) == 0);
      step("rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
